stack_sequencer: RTL
====================

Name: stack_sequencer

Overview:
- Synchronous command front-end that drives the pulse-controlled 4-bit Stack block.
- Accepts one-word operations over a valid/ready interface and converts each into correctly sequenced Push/Pop/Reset pulses, including tri-state control of the shared data bus.
- Binary ALU ops pop two operands, compute, and push the result back, which gives the machine a small RPN evaluator.
- Tracks stack depth itself so the Stack never sees an overflow or underflow.

Parameters:
- WIDTH, 4, data width; must equal the Stack data width.
- MAX_DEPTH, 7, usable entries. After its reset the Stack stores into slots 1..7, so this must be at most 7.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- CmdValid  in  1  command present.
- CmdReady  out  1  high only in IDLE.
- CmdOp  in  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 XOR, 7 CLR.
- CmdData  in  WIDTH  PUSH operand.
- RespValid  out  1  one-cycle completion pulse.
- Result  out  WIDTH  popped value or ALU result; 0 for PUSH, NOP, CLR and errors.
- RespErr  out  1  command rejected, or StkErr seen.
- RespZero  out  1  Result == 0 (qualified by RespValid).
- Depth  out  4  current entry count, 0..MAX_DEPTH.
- StkPush  out  1  to Stack Push.
- StkPop  out  1  to Stack Pop.
- StkReset  out  1  to Stack Reset (active-high).
- StkData  inout  WIDTH  to Stack DataIO.
- StkErr  in  1  from Stack Err.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - State IDLE; CmdReady 1.
  - StkPush, StkPop, RespValid, RespErr, RespZero all 0; Result 0; Depth 0.
  - StkData driver off (Z).
  - StkReset = !Reset_n OR clr_pulse_reg, so the Stack is held in reset while Reset_n is low.
- All other outputs are registered.
- Handshake: a command is accepted on the rising edge where CmdValid && CmdReady (edge T). Nothing else is accepted until RespValid has been given.
- Bus rule: StkData is driven only in PSH_SET and PSH_HI. Elsewhere it is Z; the Stack drives the bus while Pop is high.
- States: IDLE, POP_HI, POP_LO, PSH_SET, PSH_HI, CLR_HI, RESP.
- POP_HI: StkPop=1. On exit, sample StkData into OpA (first pop, the top) or OpB (second pop).
- POP_LO: StkPop=0 for one cycle so the Stack releases the bus.
- PSH_SET: data driven, StkPush=0 (setup cycle).
- PSH_HI: StkPush=1, data held. On exit StkPush=0 and the driver turns off on the same edge.
- CLR_HI: StkReset=1 for one cycle.
- RESP: RespValid=1 for one cycle, then IDLE.
- Legality is checked at acceptance. On an illegal command: go straight to RESP with RespErr=1, Result=0, no Stack pulses, Depth unchanged.
  - PUSH is illegal when Depth==MAX_DEPTH.
  - POP is illegal when Depth==0.
  - Binary ops are illegal when Depth<2.
- Sequences and latency (RespValid is high in the cycle after the listed edge):
  - NOP / error: T. Path T to RESP.
  - PUSH: T+2. Path PSH_SET, PSH_HI, RESP. Depth+1.
  - POP: T+2. Path POP_HI, POP_LO, RESP. Result=OpA, Depth-1.
  - Binary op: T+6. Path POP_HI, POP_LO, POP_HI, POP_LO, PSH_SET, PSH_HI, RESP. The push word is alu(OpB, OpA), registered on entry to PSH_SET. Result is that word. Depth-1 net.
  - CLR: T+1. Path CLR_HI, RESP. Depth 0. Legal at any depth.
- ALU, all modulo 2^WIDTH with carry/borrow discarded:
  - ADD = OpB+OpA.
  - SUB = OpB-OpA (next-below minus top).
  - AND = OpB&OpA.
  - XOR = OpB^OpA.
- StkErr sampled high during any state of the current command: RespErr=1 in RESP. Depth and Result are unaffected.
- Depth updates on the edge that enters RESP.

Decomposition:
- stack_seq_pkg holds:
  - the op_t enum (8 codes above) and state_t enum;
  - WIDTH_DEFAULT=4 and MAX_DEPTH_DEFAULT=7;
  - a localparam for the depth width.
- Sub-module stack_alu: purely combinational, inputs (op_t, a, b), output result. Unit-tested separately.

Test Plan:
- Reset: hold Reset_n=0 -> StkReset=1, StkData Z, CmdReady=1, Depth=0, RespValid=0. Release -> StkReset=0 on the next cycle.
- Basic flow: PUSH 3, PUSH 5, ADD -> Result=8, Depth=1, RespValid 7 cycles after accept, exactly 2 Pop pulses and 1 Push pulse. Then POP -> Result=8, Depth=0.
- SUB and zero flag:
  - PUSH 2, PUSH 5, SUB -> Result=0xD, RespZero=0.
  - PUSH 0xA, PUSH 0xA, XOR -> Result=0, RespZero=1.
- Bounds:
  - 7 PUSHes OK; 8th -> RespErr=1, no StkPush edge, Depth=7.
  - After CLR -> Depth=0.
  - POP -> RespErr, no StkPop edge.
  - PUSH 1 then ADD -> RespErr, Depth=1.
- Bus integrity: monitor StkData every cycle -> never driven by both sides; X-free when StkPop=1; Z in IDLE.
- Reset mid-op: assert Reset_n=0 in the second POP_HI of an ADD -> StkPop=0 and driver off immediately, Depth=0, no RespValid. After release, PUSH 4, POP -> Result=4.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared types and defaults for the stack sequencer: command opcodes, FSM states
// and the depth counter width.
package stack_seq_pkg;

  localparam int WIDTH_DEFAULT     = 4;
  localparam int MAX_DEPTH_DEFAULT = 7;
  localparam int DEPTH_W           = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_XOR  = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP_HI  = 3'd1,
    S_POP_LO  = 3'd2,
    S_PSH_SET = 3'd3,
    S_PSH_HI  = 3'd4,
    S_CLR_HI  = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  function automatic logic is_binary(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the binary stack ops; a is the next-below operand, b the top.
// All results wrap modulo 2^WIDTH.
module stack_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Command front-end for the pulse-controlled Stack: turns valid/ready commands into
// Push/Pop/Reset pulse sequences, evaluates binary RPN ops and tracks depth.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic [2:0]         CmdOp,
  input  logic [WIDTH-1:0]   CmdData,
  output logic               RespValid,
  output logic [WIDTH-1:0]   Result,
  output logic               RespErr,
  output logic               RespZero,
  output logic [DEPTH_W-1:0] Depth,
  output logic               StkPush,
  output logic               StkPop,
  output logic               StkReset,
  inout  wire  [WIDTH-1:0]   StkData,
  input  logic               StkErr
);

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  state_t           state;
  op_t              op_r;
  op_t              cmd_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] drv_data;
  logic [WIDTH-1:0] alu_out;
  logic             drv_en;
  logic             clr_pulse;
  logic             second;
  logic             err_seen;
  logic             illegal;

  assign cmd_op   = op_t'(CmdOp);
  assign StkReset = !Reset_n || clr_pulse;
  assign StkData  = drv_en ? drv_data : {WIDTH{1'bz}};

  // Operand order: a is the next-below entry (second pop), b the top (first pop).
  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_r),
    .a      (op_b),
    .b      (op_a),
    .result (alu_out)
  );

  always_comb begin
    illegal = 1'b0;
    if (cmd_op == OP_PUSH)
      illegal = (Depth == MAX_D);
    else if (cmd_op == OP_POP)
      illegal = (Depth == '0);
    else if (is_binary(cmd_op))
      illegal = (Depth < DEPTH_W'(2));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      op_r      <= OP_NOP;
      CmdReady  <= 1'b1;
      RespValid <= 1'b0;
      RespErr   <= 1'b0;
      RespZero  <= 1'b0;
      Result    <= '0;
      Depth     <= '0;
      StkPush   <= 1'b0;
      StkPop    <= 1'b0;
      clr_pulse <= 1'b0;
      drv_en    <= 1'b0;
      drv_data  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      second    <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      if (state != S_IDLE && StkErr)
        err_seen <= 1'b1;

      case (state)
        S_IDLE: begin
          if (CmdValid) begin
            op_r     <= cmd_op;
            CmdReady <= 1'b0;
            second   <= 1'b0;
            err_seen <= 1'b0;
            if (illegal || cmd_op == OP_NOP) begin
              // Rejected commands and NOP answer immediately with no Stack activity.
              RespValid <= 1'b1;
              RespErr   <= illegal;
              Result    <= '0;
              RespZero  <= 1'b1;
              state     <= S_RESP;
            end else if (cmd_op == OP_PUSH) begin
              drv_data <= CmdData;
              drv_en   <= 1'b1;
              state    <= S_PSH_SET;
            end else if (cmd_op == OP_CLR) begin
              clr_pulse <= 1'b1;
              state     <= S_CLR_HI;
            end else begin
              StkPop <= 1'b1;
              state  <= S_POP_HI;
            end
          end
        end

        S_POP_HI: begin
          StkPop <= 1'b0;
          if (!second)
            op_a <= StkData;
          else
            op_b <= StkData;
          state <= S_POP_LO;
        end

        S_POP_LO: begin
          if (op_r == OP_POP) begin
            RespValid <= 1'b1;
            RespErr   <= err_seen || StkErr;
            Result    <= op_a;
            RespZero  <= (op_a == '0);
            Depth     <= Depth - DEPTH_W'(1);
            state     <= S_RESP;
          end else if (!second) begin
            second <= 1'b1;
            StkPop <= 1'b1;
            state  <= S_POP_HI;
          end else begin
            drv_data <= alu_out;
            drv_en   <= 1'b1;
            state    <= S_PSH_SET;
          end
        end

        S_PSH_SET: begin
          StkPush <= 1'b1;
          state   <= S_PSH_HI;
        end

        S_PSH_HI: begin
          // Push falls and the bus driver releases on the same edge.
          StkPush   <= 1'b0;
          drv_en    <= 1'b0;
          RespValid <= 1'b1;
          RespErr   <= err_seen || StkErr;
          if (op_r == OP_PUSH) begin
            Result   <= '0;
            RespZero <= 1'b1;
            Depth    <= Depth + DEPTH_W'(1);
          end else begin
            Result   <= drv_data;
            RespZero <= (drv_data == '0);
            Depth    <= Depth - DEPTH_W'(1);
          end
          state <= S_RESP;
        end

        S_CLR_HI: begin
          clr_pulse <= 1'b0;
          RespValid <= 1'b1;
          RespErr   <= err_seen || StkErr;
          Result    <= '0;
          RespZero  <= 1'b1;
          Depth     <= '0;
          state     <= S_RESP;
        end

        S_RESP: begin
          RespValid <= 1'b0;
          RespErr   <= 1'b0;
          CmdReady  <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          StkPush   <= 1'b0;
          StkPop    <= 1'b0;
          drv_en    <= 1'b0;
          clr_pulse <= 1'b0;
          CmdReady  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
